// File: rtl/fir_seq_pkg.sv
// Shared definitions for the FIR sequencer: FSM state encodings and the
// register-file layout (sample history first, coefficients right after).
package fir_seq_pkg;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_MAC   = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Register 0 is kept out of the layout so it is never written.
  localparam logic [3:0] SAMP_BASE = 4'd1;

  // Coefficient block starts directly after the TAPS sample slots.
  function automatic logic [3:0] coef_base(input int taps);
    return SAMP_BASE + 4'(taps);
  endfunction

endpackage

// File: rtl/fir_seq_mac.sv
// Multiply-accumulate datapath: W-bit signed product truncated to its low W
// bits, added into a wrapping accumulator with a synchronous clear.
module fir_seq_mac #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic signed [W-1:0] prod_s;
  logic        [W-1:0] acc_q;
  logic        [W-1:0] acc_d;

  // Product and running sum; only the low W bits of the product are kept,
  // and those are identical for signed and unsigned operands.
  always_comb begin
    prod_s = $signed(a_i) * $signed(b_i);
    sum_o  = acc_q + prod_s;
    if (clr_i) begin
      acc_d = {W{1'b0}};
    end else if (en_i) begin
      acc_d = sum_o;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= {W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_seq.sv
// Direct-form FIR sequencer driving an external dual-read/dual-write 16xW
// register file. Samples live in a circular history, coefficients in a
// separate block loaded through write port 2.
module fir_seq
  import fir_seq_pkg::*;
#(
  parameter int TAPS = 4,
  parameter int W    = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         cfg_we,
  output logic         cfg_ready,
  input  logic [2:0]   cfg_idx,
  input  logic [W-1:0] cfg_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         rf_we1,
  output logic         rf_we2,
  output logic [3:0]   rf_a1,
  output logic [3:0]   rf_a2,
  output logic [3:0]   rf_wa1,
  output logic [3:0]   rf_wa2,
  output logic [W-1:0] rf_wd1,
  output logic [W-1:0] rf_wd2,
  input  logic [W-1:0] rf_rd1,
  input  logic [W-1:0] rf_rd2
);

  localparam logic [2:0] TAPS_L    = 3'(TAPS);
  localparam logic [2:0] LAST_TAP  = 3'(TAPS - 1);
  localparam logic [2:0] LAST_CLR  = 3'((TAPS + 1) / 2 - 1);
  localparam logic [3:0] COEF_BASE = coef_base(TAPS);

  logic [1:0]   state_q, state_d;
  logic [2:0]   head_q, head_d;
  logic [2:0]   k_q, k_d;
  logic [2:0]   clr_q, clr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;

  logic [2:0]   head_nxt_s;
  logic [2:0]   tap_s;
  logic         mac_clr_s;
  logic         mac_en_s;
  logic [W-1:0] mac_sum_s;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Ring-buffer arithmetic: next write slot and the slot read for tap k.
  always_comb begin
    if (head_q == LAST_TAP) begin
      head_nxt_s = 3'd0;
    end else begin
      head_nxt_s = head_q + 3'd1;
    end
    if (head_q >= k_q) begin
      tap_s = head_q - k_q;
    end else begin
      tap_s = head_q + TAPS_L - k_q;
    end
  end

  // FSM next state, handshakes and register-file port control; everything
  // towards the register file is forced quiet while reset is held.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    k_d         = k_q;
    clr_d       = clr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready    = 1'b0;
    cfg_ready   = 1'b0;
    rf_we1      = 1'b0;
    rf_wa1      = 4'd0;
    rf_wd1      = {W{1'b0}};
    rf_we2      = 1'b0;
    rf_wa2      = 4'd0;
    rf_wd2      = {W{1'b0}};
    rf_a1       = 4'd0;
    rf_a2       = 4'd0;
    mac_clr_s   = 1'b0;
    mac_en_s    = 1'b0;
    if (!reset_n) begin
      in_ready  = 1'b0;
      cfg_ready = 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // Zero two history slots per cycle; coefficients are left alone.
          rf_we1 = 1'b1;
          rf_wa1 = SAMP_BASE + {clr_q, 1'b0};
          if ({clr_q, 1'b1} < 4'(TAPS)) begin
            rf_we2 = 1'b1;
            rf_wa2 = SAMP_BASE + {clr_q, 1'b1};
          end else begin
            rf_we2 = 1'b0;
          end
          if (clr_q == LAST_CLR) begin
            clr_d   = 3'd0;
            state_d = ST_IDLE;
          end else begin
            clr_d = clr_q + 3'd1;
          end
        end
        ST_IDLE: begin
          in_ready  = 1'b1;
          cfg_ready = 1'b1;
          if (in_valid) begin
            rf_we1    = 1'b1;
            rf_wa1    = SAMP_BASE + {1'b0, head_nxt_s};
            rf_wd1    = in_data;
            head_d    = head_nxt_s;
            k_d       = 3'd0;
            mac_clr_s = 1'b1;
            state_d   = ST_MAC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MAC: begin
          // Newest sample pairs with c0, oldest with c(TAPS-1).
          rf_a1    = SAMP_BASE + {1'b0, tap_s};
          rf_a2    = COEF_BASE + {1'b0, k_q};
          mac_en_s = 1'b1;
          if (k_q == LAST_TAP) begin
            k_d         = 3'd0;
            out_data_d  = mac_sum_s;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
        ST_OUT: begin
          cfg_ready = 1'b1;
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_CLEAR;
          clr_d   = 3'd0;
        end
      endcase
      // Coefficient writes use port 2; out-of-range indices are dropped.
      if (cfg_ready && cfg_we && (cfg_idx < TAPS_L)) begin
        rf_we2 = 1'b1;
        rf_wa2 = COEF_BASE + {1'b0, cfg_idx};
        rf_wd2 = cfg_data;
      end else begin
        mac_en_s = mac_en_s & reset_n;
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      head_q      <= LAST_TAP;
      k_q         <= 3'd0;
      clr_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= {W{1'b0}};
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      k_q         <= k_d;
      clr_q       <= clr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  fir_seq_mac #(
    .W(W)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (mac_clr_s),
    .en_i    (mac_en_s),
    .a_i     (rf_rd1),
    .b_i     (rf_rd2),
    .sum_o   (mac_sum_s)
  );

endmodule

// File: tb/tb_fir_seq.sv
// Directed bench for fir_seq with TAPS=4: a behavioural 16x32 register file
// sits beside the sequencer; expected outputs are hand-computed.
module tb_fir_seq;

  localparam int TAPS = 4;
  localparam int W    = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready;
  logic [W-1:0] in_data;
  logic         cfg_we, cfg_ready;
  logic [2:0]   cfg_idx;
  logic [W-1:0] cfg_data;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic         rf_we1, rf_we2;
  logic [3:0]   rf_a1, rf_a2, rf_wa1, rf_wa2;
  logic [W-1:0] rf_wd1, rf_wd2, rf_rd1, rf_rd2;

  logic [W-1:0] rf [16];
  logic         preload;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  // Register file model: preload a junk pattern, then two write ports.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'hA5A5_0000 + 32'(i);
    end else begin
      if (rf_we1) rf[rf_wa1] <= rf_wd1;
      if (rf_we2) rf[rf_wa2] <= rf_wd2;
    end
  end

  assign rf_rd1 = rf[rf_a1];
  assign rf_rd2 = rf[rf_a2];

  fir_seq #(.TAPS(TAPS), .W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rf_we1(rf_we1), .rf_we2(rf_we2), .rf_a1(rf_a1), .rf_a2(rf_a2),
    .rf_wa1(rf_wa1), .rf_wa2(rf_wa2), .rf_wd1(rf_wd1), .rf_wd2(rf_wd2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one sample from IDLE, optionally poke a config write during MAC,
  // wait for the output and check latency and value (output left pending).
  task automatic run_sample(input logic [W-1:0] x, input logic [3:0] wa,
                            input logic [W-1:0] y, input bit poke);
    int cnt;
    in_valid = 1'b1;
    in_data  = x;
    #1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    check("we1_sample", 32'(rf_we1), 32'd1);
    check("wa1_sample", 32'(rf_wa1), 32'(wa));
    tick;
    in_valid = 1'b0;
    in_data  = '0;
    cfg_we   = 1'b0;
    if (poke) begin
      cfg_we   = 1'b1;
      cfg_idx  = 3'd0;
      cfg_data = 32'd99;
      #1;
      check("cfg_ready_mac", 32'(cfg_ready), 32'd0);
      check("we2_mac", 32'(rf_we2), 32'd0);
    end
    check("in_ready_mac", 32'(in_ready), 32'd0);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      tick;
      cnt++;
      cfg_we = 1'b0;
    end
    check("latency", 32'(cnt), 32'(TAPS));
    check("out_data", out_data, y);
  endtask

  initial begin
    int cnt;
    reset_n   = 1'b0;
    preload   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_we    = 1'b0;
    cfg_idx   = 3'd0;
    cfg_data  = '0;
    out_ready = 1'b1;
    tick;
    tick;
    preload = 1'b0;
    tick;

    // Held in reset.
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_we1", 32'(rf_we1), 32'd0);
    check("rst_wa1", 32'(rf_wa1), 32'd0);

    // CLEAR for two cycles, then IDLE.
    reset_n = 1'b1;
    #1;
    check("clr0_in_ready", 32'(in_ready), 32'd0);
    check("clr0_wa1", 32'(rf_wa1), 32'd1);
    check("clr0_wa2", 32'(rf_wa2), 32'd2);
    tick;
    check("clr1_in_ready", 32'(in_ready), 32'd0);
    check("clr1_wa2", 32'(rf_wa2), 32'd4);
    tick;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i <= 4; i++) check("samp_cleared", rf[i], 32'd0);
    check("coef_kept", rf[5], 32'hA5A5_0005);

    // Load coefficients 1,2,3,4.
    for (int k = 0; k < 4; k++) begin
      cfg_we   = 1'b1;
      cfg_idx  = 3'(k);
      cfg_data = 32'(k + 1);
      #1;
      check("cfg_we2", 32'(rf_we2), 32'd1);
      check("cfg_wa2", 32'(rf_wa2), 32'(5 + k));
      tick;
    end
    cfg_we = 1'b0;

    // Impulse-style sequence; the fifth sample wraps the head back to slot 1.
    run_sample(32'd10, 4'd1, 32'd10, 1'b0);  tick;
    run_sample(32'd20, 4'd2, 32'd40, 1'b0);  tick;
    run_sample(32'd30, 4'd3, 32'd100, 1'b0); tick;
    run_sample(32'd40, 4'd4, 32'd200, 1'b0); tick;
    run_sample(32'd50, 4'd1, 32'd300, 1'b0); tick;
    check("in_ready_after", 32'(in_ready), 32'd1);

    // Backpressure: 60+2*50+3*40+4*30 = 400 held for five cycles.
    out_ready = 1'b0;
    run_sample(32'd60, 4'd2, 32'd400, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'd400);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    check("bp_cfg_ready", 32'(cfg_ready), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_still_valid", 32'(out_valid), 32'd1);
    tick;
    check("bp_released", 32'(out_valid), 32'd0);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Config write during MAC is dropped: 70+2*60+3*50+4*40 = 500.
    run_sample(32'd70, 4'd3, 32'd500, 1'b1); tick;
    check("coef0_unchanged", rf[5], 32'd1);

    // Out-of-range index in IDLE is dropped at the port.
    cfg_we   = 1'b1;
    cfg_idx  = 3'd5;
    cfg_data = 32'd77;
    #1;
    check("idx5_cfg_ready", 32'(cfg_ready), 32'd1);
    check("idx5_we2", 32'(rf_we2), 32'd0);
    check("idx5_wa2", 32'(rf_wa2), 32'd0);

    // Sample and c3=0 in the same cycle: 80+2*70+3*60+0 = 400.
    in_valid = 1'b1;
    in_data  = 32'd80;
    cfg_idx  = 3'd3;
    cfg_data = 32'd0;
    #1;
    check("sim_we1", 32'(rf_we1), 32'd1);
    check("sim_we2", 32'(rf_we2), 32'd1);
    check("sim_wa2", 32'(rf_wa2), 32'd8);
    run_sample(32'd80, 4'd4, 32'd400, 1'b0); tick;
    check("coef3_zero", rf[8], 32'd0);

    // Reset two cycles into MAC abandons the computation.
    in_valid = 1'b1;
    in_data  = 32'd90;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_a1", 32'(rf_a1), 32'd0);
    tick;
    tick;
    check("mid_rst_valid2", 32'(out_valid), 32'd0);
    reset_n = 1'b1;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 10) begin
      tick;
      cnt++;
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    check("post_rst_clear_len", 32'(cnt), 32'd2);
    for (int i = 1; i <= 4; i++) check("post_rst_cleared", rf[i], 32'd0);
    run_sample(32'd10, 4'd1, 32'd10, 1'b0); tick;
    check("reg0_untouched", rf[0], 32'hA5A5_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
